npu_mac_seq: RTL
================

# npu_mac_seq

Sequencer for the IMC-22 NPU 16-MAC array (`npu_mac_array`). It turns a start command into one complete dot-product job:
- clears the array accumulator;
- streams `cfg_len` 16-lane chunks from the weight and activation buffers into the array;
- waits out the array pipeline, captures the 32-bit result and reports completion with a done pulse.

It sits between the NPU command path and the array/buffer datapath.

## Interface
Parameters:
- `AW`, 10: buffer address width (chunk-granular, one address = 16 lanes).
- `LEN_W`, 8: width of the chunk-count field.
- `ARRAY_LAT`, 2: cycles from the last gated-in lane data to a stable array `result`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; accepted only in IDLE.
- `abort`  in  1  cancels the running job.
- `cfg_len`  in  LEN_W  chunk count; sampled at accept.
- `cfg_w_base`  in  AW  weight buffer base address; sampled at accept.
- `cfg_x_base`  in  AW  activation buffer base address; sampled at accept.
- `w_rd_en`, `x_rd_en`  out  1  buffer read strobes. Read latency is exactly 1 cycle.
- `w_addr`, `x_addr`  out  AW  buffer read addresses.
- `feed_en`  out  1  lane gate. When 0, the datapath drives all 16 weight/input lanes to 0.
- `acc_clear`  out  1  drives the array `acc_clear`.
- `array_result`  in  32  from the array `result`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  one-cycle abort acknowledge.
- `result_out`  out  32  captured dot product, signed.

## Operation
FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE:** on `start`=1, latch the cfg fields and go to CLEAR. `start` is ignored in every other state.
- **CLEAR (1 cycle):** `acc_clear`=1.
  - `len`=0 → DONE, and `result_out` is loaded with 0. The array is not sampled.
  - otherwise → FEED.
- **FEED (`len` cycles, k = 0..len-1):**
  - `w_rd_en`=`x_rd_en`=1.
  - `w_addr`=`w_base`+k and `x_addr`=`x_base`+k, both modulo 2^AW (wrap-around is legal, no error).
  - After k = len-1 → DRAIN.
- **`feed_en`:** a 1-cycle delayed copy of the FEED read strobe. It is therefore high for exactly `len` consecutive cycles, aligned with the returning buffer data.
- **DRAIN (`ARRAY_LAT`+1 cycles):** no reads. On the last DRAIN cycle's edge, `array_result` is registered into `result_out` → DONE.
- **DONE (1 cycle):** `done`=1 → IDLE.
- **`abort`:** in CLEAR, FEED, DRAIN or DONE, `abort`=1 forces IDLE on the next edge.
  - `aborted`=1 for that following cycle, and no `done` is issued.
  - `result_out` is unchanged.
  - `feed_en` is forced to 0 in the cycle after abort, and `acc_clear` is asserted in that same cycle.
  - `abort` in IDLE has no effect.
  - If `abort` and `done` would coincide (abort sampled in DONE), `done` is still 1 in the DONE cycle, and `aborted` does not pulse.
- **Arithmetic:** no arithmetic on `result_out`; it is a 32-bit pass-through. Accumulator overflow is the array's behaviour and is not detected here.

## Timing
- **Reset values:** state=IDLE; `busy`, `done`, `aborted`, `w_rd_en`, `x_rd_en`, `feed_en` = 0; `acc_clear`=1 while `rst_n`=0 and in the first cycle after release, then 0; `w_addr`, `x_addr`, `result_out` = 0.
- **Reset mid-job:** identical to the reset values; the job is lost, with no `done` and no `aborted`.
- **`busy`:** 1 in every non-IDLE state.
- **Job with start sampled at edge T, `len`=L≥1:**
  - CLEAR is cycle T+1.
  - FEED covers T+2..T+L+1.
  - `feed_en` is high T+3..T+L+2.
  - DRAIN covers T+L+2..T+L+ARRAY_LAT+2.
  - `done`=1 and `result_out` is valid in cycle T+L+ARRAY_LAT+3.
  - Start-to-done is L+ARRAY_LAT+3 cycles.
- **`len`=0:** `done` in cycle T+2.
- **Back-to-back jobs:** `start` may be high in the DONE cycle's successor (IDLE). The minimum job spacing is L+ARRAY_LAT+4 cycles.
- **`result_out`:** holds its value until the next successful capture.

## Test plan
- Reset, ARRAY_LAT=2, `len`=1, weights 1..16, inputs all 1 → `acc_clear` pulse, one read at the bases, `done` in cycle T+6, `result_out`=136.
- `len`=4, w_base=1022, AW=10 → addresses 1022, 1023, 0, 1; `feed_en` high 4 cycles; `result_out` = sum of 4 chunk dot products.
- `len`=0 → `done` at T+2, `result_out`=0, no read strobes.
- `abort` in 2nd FEED cycle of a `len`=8 job → IDLE next cycle, `aborted`=1, no `done`, `result_out` keeps prior value (136).
- `start` held high throughout a job, plus a second start during DRAIN → ignored; exactly one `done`, next job accepted only from IDLE.
- `rst_n` low mid-FEED → all outputs at reset values asynchronously; new job afterwards gives the correct result.

Source files
------------

// File: rtl/npu_mac_seq_if.sv
// Command, buffer-read and array-control signals of the NPU MAC sequencer.
// slave is the sequencer side; master is the command path plus datapath side.
interface npu_mac_seq_if #(
    parameter int AW    = 10,
    parameter int LEN_W = 8
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] cfg_len;
    logic [AW-1:0]    cfg_w_base;
    logic [AW-1:0]    cfg_x_base;
    logic             w_rd_en;
    logic             x_rd_en;
    logic [AW-1:0]    w_addr;
    logic [AW-1:0]    x_addr;
    logic             feed_en;
    logic             acc_clear;
    logic [31:0]      array_result;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [31:0]      result_out;

    modport slave (
        input  start, abort, cfg_len, cfg_w_base, cfg_x_base, array_result,
        output w_rd_en, x_rd_en, w_addr, x_addr, feed_en, acc_clear,
               busy, done, aborted, result_out
    );

    modport master (
        output start, abort, cfg_len, cfg_w_base, cfg_x_base, array_result,
        input  w_rd_en, x_rd_en, w_addr, x_addr, feed_en, acc_clear,
               busy, done, aborted, result_out
    );
endinterface

// File: rtl/npu_mac_seq.sv
// Job sequencer for the 16-MAC array: clear, stream len chunks, drain the
// array pipeline, capture the 32-bit dot product and pulse done.
module npu_mac_seq #(
    parameter int AW        = 10,
    parameter int LEN_W     = 8,
    parameter int ARRAY_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    npu_mac_seq_if.slave   seq_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // DRAIN lasts ARRAY_LAT+1 cycles: counter runs 0..ARRAY_LAT.
    localparam logic [3:0] DRAIN_LAST = 4'(ARRAY_LAT);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_k;
    logic [3:0]       r_drain;
    logic [AW-1:0]    r_w_addr;
    logic [AW-1:0]    r_x_addr;
    logic             r_rd_en;
    logic             r_feed_en;
    logic             r_acc_clear;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic [31:0]      r_result;

    logic w_last_chunk;
    logic w_abort_hit;

    assign w_last_chunk = (r_k == r_len - LEN_W'(1));
    // Abort in DONE lets the done pulse stand and is not acknowledged.
    assign w_abort_hit  = seq_bus.abort && (r_state != S_IDLE) && (r_state != S_DONE);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_k         <= '0;
            r_drain     <= '0;
            r_w_addr    <= '0;
            r_x_addr    <= '0;
            r_rd_en     <= 1'b0;
            r_feed_en   <= 1'b0;
            r_acc_clear <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_result    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_acc_clear <= 1'b0;
            r_feed_en   <= r_rd_en;
            if (w_abort_hit) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_rd_en     <= 1'b0;
                r_feed_en   <= 1'b0;
                r_acc_clear <= 1'b1;
                r_aborted   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (seq_bus.start) begin
                            r_state     <= S_CLEAR;
                            r_busy      <= 1'b1;
                            r_acc_clear <= 1'b1;
                            r_len       <= seq_bus.cfg_len;
                            r_w_addr    <= seq_bus.cfg_w_base;
                            r_x_addr    <= seq_bus.cfg_x_base;
                            r_k         <= '0;
                        end
                    end
                    S_CLEAR: begin
                        if (r_len == '0) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_state <= S_FEED;
                            r_rd_en <= 1'b1;
                        end
                    end
                    S_FEED: begin
                        if (w_last_chunk) begin
                            r_state <= S_DRAIN;
                            r_rd_en <= 1'b0;
                            r_drain <= '0;
                        end else begin
                            r_k      <= r_k + LEN_W'(1);
                            r_w_addr <= r_w_addr + AW'(1);
                            r_x_addr <= r_x_addr + AW'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain == DRAIN_LAST) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= seq_bus.array_result;
                        end else begin
                            r_drain <= r_drain + 4'd1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_rd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seq_bus.w_rd_en    = r_rd_en;
    assign seq_bus.x_rd_en    = r_rd_en;
    assign seq_bus.w_addr     = r_w_addr;
    assign seq_bus.x_addr     = r_x_addr;
    assign seq_bus.feed_en    = r_feed_en;
    assign seq_bus.acc_clear  = r_acc_clear;
    assign seq_bus.busy       = r_busy;
    assign seq_bus.done       = r_done;
    assign seq_bus.aborted    = r_aborted;
    assign seq_bus.result_out = r_result;
endmodule
